combo_lock_ctrl: RTL and testbench
==================================

COMBO_LOCK_CTRL -- requirements
Module: combo_lock_ctrl

Interface
REQ-001 The block SHALL have parameter DEFAULT_COMBO, default 4'b0110, the combination loaded at reset.
REQ-002 The block SHALL have parameter MAX_ATTEMPTS, default 3, the number of consecutive wrong attempts that triggers lockout (legal range 1..3).
REQ-003 The block SHALL have parameter OPEN_CYCLES, default 16, the number of cycles Open stays asserted before auto-relock.
REQ-004 The block SHALL have parameter LOCKOUT_CYCLES, default 64, the number of cycles the lockout lasts.
REQ-005 The block SHALL have port Clock, input, 1 bit: the clock; all state changes on the rising edge.
REQ-006 The block SHALL have port Resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port X, input, 4 bits: the entered code.
REQ-008 The block SHALL have port Enter, input, 1 bit: submit key, level, asynchronous to protocol.
REQ-009 The block SHALL have port Change, input, 1 bit: change-combination key, level.
REQ-010 The block SHALL have port Open, output, 1 bit: lock released.
REQ-011 The block SHALL have port Alarm, output, 1 bit: lockout active.
REQ-012 The block SHALL have port New, output, 1 bit: combination-change mode active.
REQ-013 The block SHALL have port Fail, output, 1 bit: one-cycle pulse per rejected attempt.
REQ-014 The block SHALL have port Done, output, 1 bit: one-cycle pulse when a new combination commits.
REQ-015 The block SHALL have port Attempts, output, 2 bits: the current consecutive-failure count.

Function
REQ-016 Events SHALL be rising edges of Enter and Change, detected against a registered copy of each input; a held level SHALL produce exactly one event.
REQ-017 An event detected in cycle N SHALL update state and outputs at the rising clock edge ending cycle N, so they are visible in cycle N+1.
REQ-018 When Enter and Change events coincide, the Enter event SHALL be processed and the Change event discarded.
REQ-019 States SHALL be IDLE, OPEN, CHG_NEW, CHG_CONFIRM and LOCKOUT.
REQ-020 IDLE: an Enter event with X==combo SHALL go to OPEN and clear Attempts.
REQ-021 IDLE: a Change event with X==combo SHALL go to CHG_NEW and clear Attempts.
REQ-022 IDLE: an Enter or Change event with X!=combo SHALL pulse Fail and increment Attempts.
REQ-023 IDLE: if the increment makes Attempts equal MAX_ATTEMPTS, the block SHALL go to LOCKOUT instead of staying in IDLE.
REQ-024 OPEN: the timer SHALL count OPEN_CYCLES cycles and then return to IDLE.
REQ-025 OPEN: an Enter event SHALL return to IDLE immediately; Change events SHALL be ignored.
REQ-026 CHG_NEW: an Enter event SHALL latch X into pending and go to CHG_CONFIRM.
REQ-027 CHG_NEW: a Change event SHALL abort to IDLE with combo unchanged.
REQ-028 CHG_CONFIRM: an Enter event with X==pending SHALL commit combo<=pending, pulse Done and go to IDLE.
REQ-029 CHG_CONFIRM: an Enter event with X!=pending SHALL pulse Fail and go to IDLE with combo unchanged; Attempts SHALL be unaffected.
REQ-030 CHG_CONFIRM: a Change event SHALL abort to IDLE with combo unchanged.
REQ-031 LOCKOUT: all events SHALL be ignored; after LOCKOUT_CYCLES cycles the block SHALL go to IDLE with Attempts cleared.
REQ-032 Open, Alarm and New SHALL be Moore decodes of the state register (OPEN, LOCKOUT, and CHG_NEW or CHG_CONFIRM respectively); Fail and Done SHALL be registered.
REQ-033 The timer SHALL be shared by OPEN and LOCKOUT, be $clog2(LOCKOUT_CYCLES) bits or more, load zero on every state entry and never wrap.
REQ-034 Attempts SHALL saturate at MAX_ATTEMPTS.

Reset
REQ-035 Resetn low SHALL force state=IDLE, combo=DEFAULT_COMBO, pending=0, timer=0, Attempts=0 and Open=Alarm=New=Fail=Done=0.
REQ-036 The edge registers SHALL reset to 1, so an input held high through reset produces no event.
REQ-037 A reset mid-change SHALL discard pending, and the combination SHALL revert to DEFAULT_COMBO.

Structure
REQ-038 Package combo_lock_pkg SHALL hold the state enum and the DEFAULT_COMBO constant.
REQ-039 A sub-module rise_detect (registered rising-edge detector with reset value 1) SHALL be instantiated once for Enter and once for Change.

Verification
REQ-040 The bench SHALL check: X=6, Enter pulse -> Open=1 from the next cycle for 16 cycles, then 0; Attempts=0.
REQ-041 The bench SHALL check: X=1, Enter pulsed three times -> Fail pulses 3 times, Attempts 1,2,3, then Alarm=1 for 64 cycles; Enter with X=6 during Alarm is ignored.
REQ-042 The bench SHALL check: X=6, Change; then X=9, Enter; then X=9, Enter -> New=1 during the sequence, Done pulse, then X=9, Enter -> Open=1 and X=6 -> Fail.
REQ-043 The bench SHALL check: change to 9 with confirmation X=5 -> Fail pulse, IDLE, combo still 6.
REQ-044 The bench SHALL check: Enter and Change rising in the same cycle with X=6 -> OPEN, not CHG_NEW.
REQ-045 The bench SHALL check: Resetn low in CHG_CONFIRM after the new code 9 is committed -> IDLE, X=6 opens, X=9 fails.

Source files
------------

// File: rtl/combo_lock_pkg.sv
// Shared state type, reset combination and helpers for the combination-lock controller.
package combo_lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OPEN,
        CHG_NEW,
        CHG_CONFIRM,
        LOCKOUT
    } state_t;

    localparam logic [3:0] DEFAULT_COMBO = 4'b0110;

    // Saturating increment of the failure counter.
    function automatic logic [1:0] sat_inc(input logic [1:0] value, input logic [1:0] limit);
        return (value >= limit) ? limit : value + 2'd1;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; the history register resets high so a level
// held through reset never reads as an edge.
module rise_detect (
    input  logic Clock,
    input  logic Resetn,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) level_q <= 1'b1;
        else         level_q <= level;
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination-lock controller: open, change-combination and lockout handling
// driven by edge events on the Enter and Change keys.
module combo_lock_ctrl
    import combo_lock_pkg::*;
#(
    parameter logic [3:0]  DEFAULT_COMBO  = combo_lock_pkg::DEFAULT_COMBO,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned OPEN_CYCLES    = 16,
    parameter int unsigned LOCKOUT_CYCLES = 64
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [3:0] X,
    input  logic       Enter,
    input  logic       Change,
    output logic       Open,
    output logic       Alarm,
    output logic       New,
    output logic       Fail,
    output logic       Done,
    output logic [1:0] Attempts
);

    localparam int unsigned TIMER_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [1:0]  ATTEMPT_LIMIT = 2'(MAX_ATTEMPTS);
    localparam logic [TIMER_W-1:0] OPEN_LAST = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCKOUT_CYCLES - 1);

    state_t             state;
    logic [3:0]         combo;
    logic [3:0]         pending;
    logic [TIMER_W-1:0] timer;
    logic               enter_rise;
    logic               change_rise;
    logic               enter_ev;
    logic               change_ev;
    logic [1:0]         attempts_next;

    rise_detect u_enter_rise (
        .Clock  (Clock),
        .Resetn (Resetn),
        .level  (Enter),
        .rise   (enter_rise)
    );

    rise_detect u_change_rise (
        .Clock  (Clock),
        .Resetn (Resetn),
        .level  (Change),
        .rise   (change_rise)
    );

    // A coincident Change edge is dropped in favour of Enter.
    assign enter_ev      = enter_rise;
    assign change_ev     = change_rise & ~enter_rise;
    assign attempts_next = sat_inc(Attempts, ATTEMPT_LIMIT);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= IDLE;
            combo    <= DEFAULT_COMBO;
            pending  <= '0;
            timer    <= '0;
            Attempts <= '0;
            Fail     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Fail <= 1'b0;
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enter_ev || change_ev) begin
                        if (X == combo) begin
                            Attempts <= '0;
                            timer    <= '0;
                            state    <= enter_ev ? OPEN : CHG_NEW;
                        end else begin
                            Fail     <= 1'b1;
                            Attempts <= attempts_next;
                            if (attempts_next == ATTEMPT_LIMIT) begin
                                timer <= '0;
                                state <= LOCKOUT;
                            end
                        end
                    end
                end
                OPEN: begin
                    if (enter_ev || timer == OPEN_LAST) begin
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                CHG_NEW: begin
                    if (enter_ev) begin
                        pending <= X;
                        state   <= CHG_CONFIRM;
                    end else if (change_ev) begin
                        state <= IDLE;
                    end
                end
                CHG_CONFIRM: begin
                    if (enter_ev) begin
                        if (X == pending) begin
                            combo <= pending;
                            Done  <= 1'b1;
                        end else begin
                            Fail <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (change_ev) begin
                        state <= IDLE;
                    end
                end
                LOCKOUT: begin
                    if (timer == LOCK_LAST) begin
                        timer    <= '0;
                        Attempts <= '0;
                        state    <= IDLE;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                default: begin
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Open  = (state == OPEN);
    assign Alarm = (state == LOCKOUT);
    assign New   = (state == CHG_NEW) || (state == CHG_CONFIRM);

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Self-checking bench for combo_lock_ctrl: directed scenarios plus random key
// activity, all compared every cycle against a countdown-based behavioural model.
module tb_combo_lock_ctrl;

    localparam int OPEN_C = 16;
    localparam int LOCK_C = 64;
    localparam int MAX_A  = 3;

    logic       Clock  = 1'b0;
    logic       Resetn = 1'b1;
    logic [3:0] X      = '0;
    logic       Enter  = 1'b0;
    logic       Change = 1'b0;
    logic       Open, Alarm, New, Fail, Done;
    logic [1:0] Attempts;

    int n_checks = 0;
    int n_errors = 0;
    int open_cnt, alarm_cnt, new_cnt, fail_cnt, done_cnt;

    // Reference model: remaining-cycle countdowns and a change phase (0 none, 1 new code, 2 confirm).
    int m_combo, m_pending, m_attempts, m_open_left, m_lock_left, m_phase;
    bit m_fail, m_done, m_pe, m_pc;

    always #5 Clock = ~Clock;

    combo_lock_ctrl #(
        .DEFAULT_COMBO  (4'b0110),
        .MAX_ATTEMPTS   (MAX_A),
        .OPEN_CYCLES    (OPEN_C),
        .LOCKOUT_CYCLES (LOCK_C)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .X        (X),
        .Enter    (Enter),
        .Change   (Change),
        .Open     (Open),
        .Alarm    (Alarm),
        .New      (New),
        .Fail     (Fail),
        .Done     (Done),
        .Attempts (Attempts)
    );

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_combo = 6; m_pending = 0; m_attempts = 0;
        m_open_left = 0; m_lock_left = 0; m_phase = 0;
        m_fail = 0; m_done = 0; m_pe = 1; m_pc = 1;
    endtask

    task automatic model_update(input int x, input bit en, input bit ch);
        bit ev_e, ev_c;
        ev_e = en && !m_pe;
        ev_c = ch && !m_pc && !ev_e;
        m_pe = en; m_pc = ch;
        m_fail = 0; m_done = 0;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_attempts = 0;
        end else if (m_open_left > 0) begin
            if (ev_e) m_open_left = 0;
            else      m_open_left--;
        end else if (m_phase == 1) begin
            if (ev_e) begin m_pending = x; m_phase = 2; end
            else if (ev_c) m_phase = 0;
        end else if (m_phase == 2) begin
            if (ev_e) begin
                if (x == m_pending) begin m_combo = x; m_done = 1; end
                else m_fail = 1;
                m_phase = 0;
            end else if (ev_c) m_phase = 0;
        end else if (ev_e || ev_c) begin
            if (x == m_combo) begin
                m_attempts = 0;
                if (ev_e) m_open_left = OPEN_C;
                else      m_phase = 1;
            end else begin
                m_fail = 1;
                if (m_attempts < MAX_A) m_attempts++;
                if (m_attempts == MAX_A) m_lock_left = LOCK_C;
            end
        end
    endtask

    task automatic clr_counts();
        open_cnt = 0; alarm_cnt = 0; new_cnt = 0; fail_cnt = 0; done_cnt = 0;
    endtask

    // One clock cycle: drive, compare at the falling edge, advance the model with the rising edge.
    task automatic step(input logic [3:0] x, input logic en, input logic ch);
        X = x; Enter = en; Change = ch;
        @(negedge Clock);
        check_eq("Open",     Open,     (m_open_left > 0) ? 1 : 0);
        check_eq("Alarm",    Alarm,    (m_lock_left > 0) ? 1 : 0);
        check_eq("New",      New,      (m_phase != 0) ? 1 : 0);
        check_eq("Fail",     Fail,     m_fail);
        check_eq("Done",     Done,     m_done);
        check_eq("Attempts", Attempts, m_attempts);
        open_cnt  += Open;
        alarm_cnt += Alarm;
        new_cnt   += New;
        fail_cnt  += Fail;
        done_cnt  += Done;
        model_update(x, en, ch);
        @(posedge Clock);
        #1;
    endtask

    task automatic press(input logic [3:0] x, input logic en, input logic ch);
        step(x, en, ch);
        step(x, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic hold);
        Enter = hold; Change = hold;
        #2 Resetn = 1'b0;
        #1;
        check_eq("rst_Open",     Open,     0);
        check_eq("rst_Alarm",    Alarm,    0);
        check_eq("rst_New",      New,      0);
        check_eq("rst_Fail",     Fail,     0);
        check_eq("rst_Done",     Done,     0);
        check_eq("rst_Attempts", Attempts, 0);
        model_reset();
        @(negedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
        model_update(X, Enter, Change);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic [3:0] rx;
        logic       ren, rch;

        // Correct code opens for exactly OPEN_C cycles; a level held through reset is no event.
        do_reset(1'b1);
        step(4'd6, 1'b1, 1'b0);
        step(4'd6, 1'b1, 1'b0);
        check_eq("held_no_open", Open, 0);
        step(4'd6, 1'b0, 1'b0);
        clr_counts();
        press(4'd6, 1'b1, 1'b0);
        check_eq("open_next_cycle", Open, 1);
        repeat (20) step(4'd6, 1'b0, 1'b0);
        check_eq("open_len", open_cnt, OPEN_C);
        check_eq("open_attempts", Attempts, 0);

        // Three wrong codes lock out; a correct code during lockout is ignored.
        do_reset(1'b0);
        clr_counts();
        press(4'd1, 1'b1, 1'b0);
        check_eq("attempts_1", Attempts, 1);
        press(4'd1, 1'b1, 1'b0);
        check_eq("attempts_2", Attempts, 2);
        press(4'd1, 1'b1, 1'b0);
        check_eq("attempts_3", Attempts, 3);
        check_eq("alarm_on", Alarm, 1);
        press(4'd6, 1'b1, 1'b0);
        repeat (LOCK_C) step(4'd0, 1'b0, 1'b0);
        check_eq("lock_fail_cnt", fail_cnt, 3);
        check_eq("lock_alarm_len", alarm_cnt, LOCK_C);
        check_eq("lock_open_ignored", open_cnt, 0);
        check_eq("lock_attempts_clr", Attempts, 0);

        // Change 6 -> 9, then 9 opens, Enter relocks at once, 6 now fails.
        do_reset(1'b0);
        clr_counts();
        press(4'd6, 1'b0, 1'b1);
        check_eq("chg_new", New, 1);
        press(4'd9, 1'b1, 1'b0);
        check_eq("chg_confirm", New, 1);
        press(4'd9, 1'b1, 1'b0);
        check_eq("chg_done", done_cnt, 1);
        check_eq("chg_new_off", New, 0);
        press(4'd9, 1'b1, 1'b0);
        check_eq("new_code_opens", Open, 1);
        press(4'd0, 1'b1, 1'b0);
        check_eq("enter_relocks", Open, 0);
        clr_counts();
        press(4'd6, 1'b1, 1'b0);
        check_eq("old_code_fails", fail_cnt, 1);

        // Mismatched confirmation leaves combo at 6 and Attempts untouched.
        do_reset(1'b0);
        press(4'd6, 1'b0, 1'b1);
        press(4'd9, 1'b1, 1'b0);
        clr_counts();
        press(4'd5, 1'b1, 1'b0);
        check_eq("confirm_fail", fail_cnt, 1);
        check_eq("confirm_idle", New, 0);
        check_eq("confirm_attempts", Attempts, 0);
        press(4'd6, 1'b1, 1'b0);
        check_eq("combo_kept", Open, 1);

        // Coincident Enter and Change edges take the Enter path.
        do_reset(1'b0);
        step(4'd6, 1'b1, 1'b1);
        check_eq("both_open", Open, 1);
        check_eq("both_not_new", New, 0);
        step(4'd6, 1'b0, 1'b0);

        // Reset in the middle of a change reverts to the default combination.
        do_reset(1'b0);
        press(4'd6, 1'b0, 1'b1);
        press(4'd9, 1'b1, 1'b0);
        press(4'd9, 1'b1, 1'b0);
        press(4'd9, 1'b0, 1'b1);
        press(4'd3, 1'b1, 1'b0);
        check_eq("mid_chg_new", New, 1);
        do_reset(1'b0);
        press(4'd6, 1'b1, 1'b0);
        check_eq("rst_default_opens", Open, 1);
        press(4'd6, 1'b1, 1'b0);
        clr_counts();
        press(4'd9, 1'b1, 1'b0);
        check_eq("rst_nine_fails", fail_cnt, 1);
        check_eq("rst_nine_closed", Open, 0);

        // Random key activity with occasional resets.
        do_reset(1'b0);
        ren = 1'b0; rch = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       rx = 4'(m_combo);
                1:       rx = 4'(m_pending);
                default: rx = 4'($urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 2) == 0) ren = ~ren;
            if ($urandom_range(0, 3) == 0) rch = ~rch;
            if ($urandom_range(0, 299) == 0) do_reset(1'($urandom_range(0, 1)));
            step(rx, ren, rch);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end

endmodule
